// File: rtl/picc_rx_decoder_if.sv
// Receive-side bus between the PICC envelope front end, the decoder and the frame handler.
// The master drives enable/data; the slave (decoder) returns bytes and frame status.
interface picc_rx_decoder_if #(
    parameter int unsigned CNT_W = 5
);
    logic             enable_in;
    logic             data_in;
    logic [7:0]       byte_out;
    logic             byte_valid_out;
    logic             parity_err_out;
    logic             frame_done_out;
    logic [3:0]       partial_bits_out;
    logic [CNT_W-1:0] byte_count_out;
    logic             coding_err_out;
    logic             busy_out;

    modport master (
        output enable_in,
        output data_in,
        input  byte_out,
        input  byte_valid_out,
        input  parity_err_out,
        input  frame_done_out,
        input  partial_bits_out,
        input  byte_count_out,
        input  coding_err_out,
        input  busy_out
    );

    modport slave (
        input  enable_in,
        input  data_in,
        output byte_out,
        output byte_valid_out,
        output parity_err_out,
        output frame_done_out,
        output partial_bits_out,
        output byte_count_out,
        output coding_err_out,
        output busy_out
    );
endinterface

// File: rtl/picc_rx_decoder.sv
// ISO 14443-A PICC->PCD receive decoder: majority-voted Manchester halves, byte assembly,
// odd-parity check, short-frame reporting and coding/overflow error detection.
module picc_rx_decoder #(
    parameter int unsigned SAMPLES_PER_BIT = 16,
    parameter int unsigned MAX_BYTES       = 16,
    parameter int unsigned CNT_W           = $clog2(MAX_BYTES + 1)
) (
    input logic              clk_in,
    input logic              rst_in,
    picc_rx_decoder_if.slave bus
);

    localparam int unsigned HALF = SAMPLES_PER_BIT / 2;
    localparam int unsigned VOTE = HALF / 2;
    localparam int unsigned PH_W = $clog2(SAMPLES_PER_BIT);
    localparam int unsigned HC_W = $clog2(HALF + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_SOF,
        ST_DATA,
        ST_QUIET
    } state_t;

    state_t           state_q, state_d;
    logic             sync_q, ds_q;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [HC_W-1:0]  ones_a_q, ones_a_d;
    logic [HC_W-1:0]  ones_b_q, ones_b_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             byte_valid_q, byte_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_done_q, frame_done_d;
    logic             coding_err_q, coding_err_d;
    logic             busy_q, busy_d;
    logic [3:0]       partial_q, partial_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [HC_W-1:0]  ones_b_total;
    logic             half_a, half_b, last_phase;

    // Two-flop synchronizer for the asynchronous subcarrier-presence input
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q <= 1'b0;
            ds_q   <= 1'b0;
        end else begin
            sync_q <= bus.data_in;
            ds_q   <= sync_q;
        end
    end

    // Half votes; at the last phase the first half is complete and the second still needs ds
    assign ones_b_total = ones_b_q + HC_W'(ds_q);
    assign half_a       = ones_a_q >= HC_W'(VOTE);
    assign half_b       = ones_b_total >= HC_W'(VOTE);
    assign last_phase   = phase_q == PH_W'(SAMPLES_PER_BIT - 1);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            ones_a_q     <= '0;
            ones_b_q     <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_done_q <= 1'b0;
            coding_err_q <= 1'b0;
            busy_q       <= 1'b0;
            partial_q    <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            ones_a_q     <= ones_a_d;
            ones_b_q     <= ones_b_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            parity_err_q <= parity_err_d;
            frame_done_q <= frame_done_d;
            coding_err_q <= coding_err_d;
            busy_q       <= busy_d;
            partial_q    <= partial_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        ones_a_d     = ones_a_q;
        ones_b_d     = ones_b_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_done_d = 1'b0;
        coding_err_d = 1'b0;
        busy_d       = busy_q;
        partial_d    = partial_q;
        count_d      = count_q;

        if (!bus.enable_in) begin
            state_d   = ST_IDLE;
            phase_d   = '0;
            ones_a_d  = '0;
            ones_b_d  = '0;
            bit_idx_d = '0;
            shift_d   = '0;
            busy_d    = 1'b0;
            partial_d = '0;
            count_d   = '0;
        end else begin
            // Free-running bit timing shared by SOF and DATA
            if (state_q == ST_SOF || state_q == ST_DATA) begin
                if (phase_q < PH_W'(HALF)) begin
                    ones_a_d = ones_a_q + HC_W'(ds_q);
                end else begin
                    ones_b_d = ones_b_q + HC_W'(ds_q);
                end
                phase_d = phase_q + PH_W'(1);
                if (last_phase) begin
                    phase_d  = '0;
                    ones_a_d = '0;
                    ones_b_d = '0;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    state_d = ST_HUNT;
                    phase_d = '0;
                end

                ST_HUNT: begin
                    phase_d  = '0;
                    ones_a_d = '0;
                    ones_b_d = '0;
                    // The detecting cycle is sample 0 of the SOF bit
                    if (ds_q) begin
                        state_d  = ST_SOF;
                        phase_d  = PH_W'(1);
                        ones_a_d = HC_W'(1);
                    end
                end

                ST_SOF: begin
                    if (last_phase) begin
                        if (half_a && !half_b) begin
                            state_d   = ST_DATA;
                            busy_d    = 1'b1;
                            count_d   = '0;
                            bit_idx_d = '0;
                            shift_d   = '0;
                            partial_d = '0;
                        end else begin
                            state_d = ST_HUNT;
                        end
                    end
                end

                ST_DATA: begin
                    if (last_phase) begin
                        if (half_a ^ half_b) begin
                            if (bit_idx_q == 4'd8) begin
                                if (count_q == CNT_W'(MAX_BYTES)) begin
                                    // Overflow: drop the byte and abort the frame
                                    state_d      = ST_QUIET;
                                    frame_done_d = 1'b1;
                                    coding_err_d = 1'b1;
                                    busy_d       = 1'b0;
                                end else begin
                                    byte_valid_d = 1'b1;
                                    byte_d       = shift_q;
                                    parity_err_d = ~((^shift_q) ^ half_a);
                                    count_d      = count_q + CNT_W'(1);
                                    bit_idx_d    = '0;
                                    shift_d      = '0;
                                end
                            end else begin
                                shift_d[bit_idx_q[2:0]] = half_a;
                                bit_idx_d               = bit_idx_q + 4'd1;
                            end
                        end else if (!half_a) begin
                            // End of frame; a whole-byte frame keeps the last byte on byte_out
                            state_d      = ST_HUNT;
                            frame_done_d = 1'b1;
                            busy_d       = 1'b0;
                            partial_d    = bit_idx_q;
                            if (bit_idx_q != 4'd0) begin
                                byte_d = shift_q;
                            end
                        end else begin
                            state_d      = ST_QUIET;
                            frame_done_d = 1'b1;
                            coding_err_d = 1'b1;
                            busy_d       = 1'b0;
                        end
                    end
                end

                ST_QUIET: begin
                    // Require one full bit period of silence before hunting again
                    if (ds_q) begin
                        phase_d = '0;
                    end else if (last_phase) begin
                        state_d = ST_HUNT;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.byte_out         = byte_q;
    assign bus.byte_valid_out   = byte_valid_q;
    assign bus.parity_err_out   = parity_err_q;
    assign bus.frame_done_out   = frame_done_q;
    assign bus.partial_bits_out = partial_q;
    assign bus.byte_count_out   = count_q;
    assign bus.coding_err_out   = coding_err_q;
    assign bus.busy_out         = busy_q;

endmodule

// File: tb/tb_picc_rx_decoder.sv
// Directed bench for picc_rx_decoder: table of whole frames plus hand-written
// glitch, quiet-period and enable-abort sequences.
module tb_picc_rx_decoder;

    localparam int unsigned SPB = 16;
    localparam int unsigned NV  = 8;

    logic clk;
    logic rst;

    picc_rx_decoder_if #(.CNT_W(2)) bus ();

    picc_rx_decoder #(
        .SAMPLES_PER_BIT(SPB),
        .MAX_BYTES      (2),
        .CNT_W          (2)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bits;
        logic [31:0] nbits;
        logic        bad_end;
        logic [31:0] exp_valid;
        logic [7:0]  b0;
        logic        p0;
        logic [7:0]  b1;
        logic        p1;
        logic [7:0]  fd_byte;
        logic [31:0] partial;
        logic [31:0] count;
        logic        coding;
    } vec_t;

    vec_t vec [NV];

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Output monitor, sampled on the falling edge
    int unsigned n_valid = 0;
    int unsigned n_fd    = 0;
    int unsigned n_busy  = 0;
    int unsigned n_bad   = 0;
    logic [7:0]  vb [64];
    logic        vp [64];
    logic [7:0]  fd_byte;
    logic [3:0]  fd_partial;
    logic [1:0]  fd_count;
    logic        fd_coding;

    always @(negedge clk) begin
        if (bus.byte_valid_out) begin
            vb[n_valid[5:0]] <= bus.byte_out;
            vp[n_valid[5:0]] <= bus.parity_err_out;
            n_valid          <= n_valid + 1;
        end
        if (bus.frame_done_out) begin
            fd_byte    <= bus.byte_out;
            fd_partial <= bus.partial_bits_out;
            fd_count   <= bus.byte_count_out;
            fd_coding  <= bus.coding_err_out;
            n_fd       <= n_fd + 1;
            if (bus.busy_out) n_bad <= n_bad + 1;
        end
        if (bus.coding_err_out && !bus.frame_done_out) n_bad <= n_bad + 1;
        if (bus.busy_out) n_busy <= n_busy + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] bits, input int nbits, input logic bad_end,
                                 input int exp_valid, input logic [7:0] b0, input logic p0,
                                 input logic [7:0] b1, input logic p1, input logic [7:0] fdb,
                                 input int partial, input int count, input logic coding);
        vec_t v;
        v.bits = bits; v.nbits = 32'(nbits); v.bad_end = bad_end;
        v.exp_valid = 32'(exp_valid); v.b0 = b0; v.p0 = p0; v.b1 = b1; v.p1 = p1;
        v.fd_byte = fdb; v.partial = 32'(partial); v.count = 32'(count); v.coding = coding;
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.data_in = 1'b0;
        end
    endtask

    // One bit period: first-half level a, second-half level b
    task automatic send_sym(input logic a, input logic b);
        for (int i = 0; i < int'(SPB); i++) begin
            @(negedge clk);
            bus.data_in = (i < int'(SPB / 2)) ? a : b;
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input logic [31:0] nbits, input logic bad_end);
        send_sym(1'b1, 1'b0);
        for (int i = 0; i < int'(nbits); i++) send_sym(bits[i], ~bits[i]);
        if (bad_end) send_sym(1'b1, 1'b1);
        else         send_sym(1'b0, 1'b0);
        idle(40);
    endtask

    int unsigned bv, bf, bb;

    initial begin
        vec[0] = mkv(32'h193, 9, 1'b0, 1, 8'h93, 1'b0, 8'h00, 1'b0, 8'h93, 0, 1, 1'b0);
        vec[1] = mkv(32'h026, 7, 1'b0, 0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h26, 7, 0, 1'b0);
        vec[2] = mkv(32'h101, 9, 1'b0, 1, 8'h01, 1'b1, 8'h00, 1'b0, 8'h01, 0, 1, 1'b0);
        vec[3] = mkv(32'h005, 3, 1'b1, 0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 0, 0, 1'b1);
        vec[4] = mkv({5'b0, 1'b1, 8'h3C, 1'b1, 8'hA5, 1'b1, 8'h93}, 27, 1'b0,
                     2, 8'h93, 1'b0, 8'hA5, 1'b0, 8'h00, 0, 2, 1'b1);
        vec[5] = mkv({14'b0, 1'b1, 8'hA5, 1'b0, 8'h80}, 18, 1'b0,
                     2, 8'h80, 1'b0, 8'hA5, 1'b0, 8'hA5, 0, 2, 1'b0);
        vec[6] = mkv(32'h001, 1, 1'b0, 0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h01, 1, 0, 1'b0);
        vec[7] = mkv({19'b0, 4'hA, 1'b0, 8'hFF}, 13, 1'b0,
                     1, 8'hFF, 1'b1, 8'h00, 1'b0, 8'h0A, 4, 1, 1'b0);

        rst           = 1'b1;
        bus.enable_in = 1'b0;
        bus.data_in   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_byte_out",   32'(bus.byte_out), 32'h0);
        check("reset_pulses",     32'({bus.byte_valid_out, bus.parity_err_out,
                                       bus.frame_done_out, bus.coding_err_out}), 32'h0);
        check("reset_busy",       32'(bus.busy_out), 32'h0);
        check("reset_counts",     32'({bus.partial_bits_out, bus.byte_count_out}), 32'h0);

        bus.data_in = 1'b0;
        @(negedge clk);
        rst           = 1'b0;
        bus.enable_in = 1'b1;
        idle(5);

        for (int v = 0; v < int'(NV); v++) begin
            bv = n_valid;
            bf = n_fd;
            send_frame(vec[v].bits, vec[v].nbits, vec[v].bad_end);
            check($sformatf("v%0d_nvalid", v), 32'(n_valid - bv), vec[v].exp_valid);
            if (vec[v].exp_valid > 0) begin
                check($sformatf("v%0d_byte0", v),   32'(vb[bv[5:0]]), 32'(vec[v].b0));
                check($sformatf("v%0d_parerr0", v), 32'(vp[bv[5:0]]), 32'(vec[v].p0));
            end
            if (vec[v].exp_valid > 1) begin
                check($sformatf("v%0d_byte1", v),   32'(vb[bv[5:0] + 6'd1]), 32'(vec[v].b1));
                check($sformatf("v%0d_parerr1", v), 32'(vp[bv[5:0] + 6'd1]), 32'(vec[v].p1));
            end
            check($sformatf("v%0d_nframe", v), 32'(n_fd - bf), 32'h1);
            check($sformatf("v%0d_coding", v), 32'(fd_coding), 32'(vec[v].coding));
            check($sformatf("v%0d_count", v),  32'(fd_count), vec[v].count);
            if (!vec[v].coding) begin
                check($sformatf("v%0d_partial", v), 32'(fd_partial), vec[v].partial);
                check($sformatf("v%0d_fdbyte", v),  32'(fd_byte), 32'(vec[v].fd_byte));
            end
        end

        // Illegal symbol followed at once by a would-be frame: must be ignored until quiet
        bv = n_valid;
        bf = n_fd;
        send_sym(1'b1, 1'b0);
        send_sym(1'b1, 1'b0);
        send_sym(1'b0, 1'b1);
        send_sym(1'b1, 1'b0);
        send_sym(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) send_sym(1'b1, 1'b0);
        send_sym(1'b0, 1'b0);
        idle(40);
        check("quiet_nframe", 32'(n_fd - bf), 32'h1);
        check("quiet_coding", 32'(fd_coding), 32'h1);
        check("quiet_nvalid", 32'(n_valid - bv), 32'h0);

        // Three-cycle glitch in HUNT is rejected as SOF
        bv = n_valid;
        bf = n_fd;
        bb = n_busy;
        repeat (3) begin
            @(negedge clk);
            bus.data_in = 1'b1;
        end
        idle(40);
        check("glitch_nframe", 32'(n_fd - bf), 32'h0);
        check("glitch_nvalid", 32'(n_valid - bv), 32'h0);
        check("glitch_busy",   32'(n_busy - bb), 32'h0);

        // Enable dropped mid-byte aborts silently
        bf = n_fd;
        send_sym(1'b1, 1'b0);
        send_sym(1'b1, 1'b0);
        send_sym(1'b1, 1'b0);
        send_sym(1'b0, 1'b1);
        send_sym(1'b1, 1'b0);
        repeat (5) begin
            @(negedge clk);
            bus.data_in = 1'b1;
        end
        check("abort_busy_before", 32'(bus.busy_out), 32'h1);
        @(negedge clk);
        bus.enable_in = 1'b0;
        bus.data_in   = 1'b0;
        @(negedge clk);
        check("abort_busy_after", 32'(bus.busy_out), 32'h0);
        check("abort_count",      32'(bus.byte_count_out), 32'h0);
        idle(40);
        check("abort_nframe", 32'(n_fd - bf), 32'h0);

        // Re-arm and decode a normal frame
        bus.enable_in = 1'b1;
        idle(5);
        bv = n_valid;
        bf = n_fd;
        send_frame(32'h193, 32'd9, 1'b0);
        check("rearm_nvalid", 32'(n_valid - bv), 32'h1);
        check("rearm_byte",   32'(vb[bv[5:0]]), 32'h93);
        check("rearm_nframe", 32'(n_fd - bf), 32'h1);
        check("rearm_count",  32'(fd_count), 32'h1);

        check("busy_or_stray_coding", 32'(n_bad), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/picc_rx_decoder.md
Name: picc_rx_decoder

Overview:
Parametrised PICC-to-PCD receive decoder for ISO 14443-A load-modulated responses.
- Input is the 1-bit demodulated subcarrier-presence signal (1 = subcarrier present).
- Decodes Manchester symbols (D = 1, E = 0, F = end of frame) into bytes, checks odd parity, and reports short frames and coding errors.
- Sits between the ADC/envelope front end and the frame handler. Replaces the fixed 4-slot pattern matcher with a sampled, majority-voting, byte-assembling decoder.

Parameters:
- SAMPLES_PER_BIT, 16, clk_in cycles per bit period; must be even and >= 4. HALF = SAMPLES_PER_BIT/2.
- MAX_BYTES, 16, maximum complete bytes per frame before overflow.
- CNT_W, $clog2(MAX_BYTES+1), width of byte_count_out.

Ports:
- clk_in  input  1  receiver clock
- rst_in  input  1  asynchronous active-high reset
- enable_in  input  1  arm the receiver; low aborts any frame
- data_in  input  1  demodulated subcarrier presence, asynchronous to clk_in
- byte_out  output  8  decoded byte, LSB = first bit received
- byte_valid_out  output  1  one-cycle pulse, byte_out valid
- parity_err_out  output  1  qualifies byte_valid_out: odd-parity failure
- frame_done_out  output  1  one-cycle pulse at end of frame
- partial_bits_out  output  4  data bits in the trailing incomplete byte (0-8); valid with frame_done_out
- byte_count_out  output  CNT_W  complete bytes in the current frame
- coding_err_out  output  1  one-cycle pulse with frame_done_out on an illegal symbol or overflow
- busy_out  output  1  high from SOF acceptance to end of frame

Behaviour:
- Reset (asynchronous, rst_in=1): state IDLE; all outputs 0; shift register, counters and synchronizer cleared.
- Input path: data_in passes through a 2-flop synchronizer. All timing below refers to the synchronized signal ds.
- Half-bit vote:
  - Count the cycles with ds=1 within each half of the bit period.
  - Half value = 1 if the count >= HALF/2.
  - Phase counter runs 0..SAMPLES_PER_BIT-1; first half is phases 0..HALF-1.
- Symbol map from (first half, second half): 10 = D (logic 1), 01 = E (logic 0), 00 = F, 11 = illegal.
- States:
  - IDLE: when enable_in=1, go to HUNT.
  - HUNT: on the first ds=1, phase := 0 (that cycle counts as sample 0); go to SOF.
  - SOF: at phase SAMPLES_PER_BIT-1, if the symbol is D, go to DATA, set busy_out=1, and clear byte_count_out and the bit counter. Any other symbol returns to HUNT with no outputs.
  - DATA: each bit period ends at phase SAMPLES_PER_BIT-1 and the symbol is decoded there.
    - D or E: shift the bit in; bit index 0-8 within the byte.
    - At index 8 (parity bit):
      - Next cycle, pulse byte_valid_out with byte_out = 8 data bits.
      - parity_err_out = 1 if the XOR of the 8 data bits and the parity bit is 0.
      - Increment byte_count_out and reset the index to 0.
    - F: end of frame. Next cycle, pulse frame_done_out, set partial_bits_out = index, put the partial bits LSB-aligned (upper bits 0) on byte_out, and go to HUNT.
    - Illegal symbol: pulse frame_done_out and coding_err_out together, go to QUIET.
    - A 9th-bit completion with byte_count_out == MAX_BYTES (overflow): the byte is not emitted; pulse frame_done_out and coding_err_out, go to QUIET.
  - QUIET: wait for ds=0 for SAMPLES_PER_BIT consecutive cycles, then go to HUNT.
- busy_out falls on the same cycle frame_done_out pulses.
- byte_count_out and partial_bits_out hold until the next SOF acceptance.
- A frame of exactly 9·n bits gives partial_bits_out=0, and byte_out holds the last byte.
- enable_in=0 in any state: go to IDLE on the next cycle; busy_out=0; no frame_done_out pulse; counters cleared.
- Latency: byte_valid_out and frame_done_out are asserted 1 cycle after the final phase of the deciding bit, i.e. 3 cycles after the last data_in sample counting the synchronizer.
- No phase resynchronisation within a frame; bit period is free-running from the SOF edge.

Test Plan:
All scenarios use SAMPLES_PER_BIT=16 and MAX_BYTES=2.
- SOF, byte 0x93 LSB-first, parity 1, F -> one byte_valid_out with 0x93 and parity_err_out=0; frame_done_out with byte_count_out=1, partial_bits_out=0.
- SOF, 7 bits 0x26, F (short frame) -> no byte_valid_out; frame_done_out with partial_bits_out=7, byte_out=0x26, byte_count_out=0.
- SOF, byte 0x01 with parity 1 (wrong) -> byte_valid_out with parity_err_out=1; frame still ends normally on F.
- Symbol with both halves modulated after 3 bits -> frame_done_out and coding_err_out in the same cycle; no new frame accepted until 16 quiet cycles.
- Three full bytes -> two byte_valid_out pulses, then coding_err_out with frame_done_out at the 3rd parity bit.
- 3-cycle glitch on data_in in HUNT -> SOF rejected (first half count 3 < 4), no outputs. enable_in dropped mid-byte -> busy_out=0 next cycle, no frame_done_out.
